// File: rtl/sensor_debouncer.sv
// Dual-channel sensor debouncer: accepts a new level only after DEBOUNCE_CYCLES consecutive differing samples.
// Optional glitch counters enabled by defining SENSOR_DEBOUNCER_GLITCH_COUNT_EN.

module sensor_debouncer_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       dout,
  output logic       rise,
  output logic       fall,
  output logic [7:0] glitches
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          stable, stable_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          rise_q, rise_next;
  logic          fall_q, fall_next;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= RESET_LEVEL;
      cnt    <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      stable <= stable_next;
      cnt    <= cnt_next;
      rise_q <= rise_next;
      fall_q <= fall_next;
    end
  end

  // Next state: count differing samples, accept on the last one, drop back to 0 on any match
  always_comb begin
    stable_next = stable;
    cnt_next    = '0;
    rise_next   = 1'b0;
    fall_next   = 1'b0;
    if (din != stable) begin
      if (cnt == LAST) begin
        stable_next = din;
        rise_next   = din;
        fall_next   = ~din;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  // Outputs
  always_comb begin
    dout = stable;
    rise = rise_q;
    fall = fall_q;
  end

`ifdef SENSOR_DEBOUNCER_GLITCH_COUNT_EN
  logic [7:0] gcnt, gcnt_next;

  // A matching sample while counting is a rejected transition; saturate at 255
  always_comb begin
    gcnt_next = gcnt;
    if ((din == stable) && (cnt != '0) && (gcnt != 8'hFF))
      gcnt_next = gcnt + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gcnt <= 8'd0;
    else       gcnt <= gcnt_next;
  end

  assign glitches = gcnt;
`else
  assign glitches = 8'd0;
`endif

endmodule

module sensor_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_in,
  input  logic       b_in,
  output logic       a_out,
  output logic       b_out,
  output logic       a_rise,
  output logic       a_fall,
  output logic       b_rise,
  output logic       b_fall,
  output logic [7:0] a_glitches,
  output logic [7:0] b_glitches
);

  sensor_debouncer_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (RESET_LEVEL)
  ) u_a (
    .clk     (clk),
    .reset   (reset),
    .din     (a_in),
    .dout    (a_out),
    .rise    (a_rise),
    .fall    (a_fall),
    .glitches(a_glitches)
  );

  sensor_debouncer_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (RESET_LEVEL)
  ) u_b (
    .clk     (clk),
    .reset   (reset),
    .din     (b_in),
    .dout    (b_out),
    .rise    (b_rise),
    .fall    (b_fall),
    .glitches(b_glitches)
  );

endmodule

// File: tb/tb_sensor_debouncer.sv
// Randomized and directed bench for sensor_debouncer against a sample-history reference model.
// Glitch expectations follow SENSOR_DEBOUNCER_GLITCH_COUNT_EN.

module tb_sensor_debouncer;
  localparam int unsigned DC = 4;
  localparam logic        RL = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a_in = 1'b0, b_in = 1'b0;
  logic       a_out, b_out, a_rise, a_fall, b_rise, b_fall;
  logic [7:0] a_glitches, b_glitches;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a level is accepted once the last DC samples all differ from it
  logic m_out  [2];
  logic m_rise [2];
  logic m_fall [2];
  int   m_gl   [2];
  logic hist   [2][DC];

  sensor_debouncer #(.DEBOUNCE_CYCLES(DC), .RESET_LEVEL(RL)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
    .a_out(a_out), .b_out(b_out), .a_rise(a_rise), .a_fall(a_fall),
    .b_rise(b_rise), .b_fall(b_fall), .a_glitches(a_glitches), .b_glitches(b_glitches)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_out[c] = RL; m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_gl[c] = 0;
      for (int k = 0; k < DC; k++) hist[c][k] = RL;
    end
  endtask

  task automatic model_step(input logic [1:0] x);
    for (int c = 0; c < 2; c++) begin
      logic prev;
      bit   all_diff;
      prev = hist[c][DC-1];
      for (int k = 0; k < DC - 1; k++) hist[c][k] = hist[c][k+1];
      hist[c][DC-1] = x[c];
      all_diff = 1'b1;
      for (int k = 0; k < DC; k++) if (hist[c][k] == m_out[c]) all_diff = 1'b0;
`ifdef SENSOR_DEBOUNCER_GLITCH_COUNT_EN
      if (x[c] == m_out[c] && prev != m_out[c] && m_gl[c] < 255) m_gl[c]++;
`else
      if (prev == 1'bx) m_gl[c] = 0;
`endif
      m_rise[c] = 1'b0; m_fall[c] = 1'b0;
      if (all_diff) begin
        m_out[c] = x[c]; m_rise[c] = x[c]; m_fall[c] = ~x[c];
        for (int k = 0; k < DC; k++) hist[c][k] = x[c];
      end
    end
  endtask

  task automatic check_all();
    check("a_out", 8'(a_out), 8'(m_out[0]));
    check("b_out", 8'(b_out), 8'(m_out[1]));
    check("a_rise", 8'(a_rise), 8'(m_rise[0]));
    check("a_fall", 8'(a_fall), 8'(m_fall[0]));
    check("b_rise", 8'(b_rise), 8'(m_rise[1]));
    check("b_fall", 8'(b_fall), 8'(m_fall[1]));
    check("a_glitches", a_glitches, 8'(m_gl[0]));
    check("b_glitches", b_glitches, 8'(m_gl[1]));
  endtask

  // Drive one sample pair (inputs change at negedge), clock it, check at the next negedge
  task automatic cycle(input logic a, input logic b);
    a_in = a; b_in = b;
    @(posedge clk);
    model_step({b, a});
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    for (int i = 0; i < n; i++) cycle(a, b);
  endtask

  // Async reset applied between edges: outputs must clear before any clock edge
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;

    // a held high: accepted on the 4th sampling edge, pulse lasts one cycle
    hold(1'b1, 1'b0, 3);
    check("a_out_pre_accept", 8'(a_out), 8'd0);
    cycle(1'b1, 1'b0);
    check("a_out_accept", 8'(a_out), 8'd1);
    check("a_rise_accept", 8'(a_rise), 8'd1);
    cycle(1'b1, 1'b0);
    check("a_rise_cleared", 8'(a_rise), 8'd0);

    // fall from stable 1
    hold(1'b0, 1'b0, 4);
    check("a_fall_pulse", 8'(a_fall), 8'd1);
    check("a_out_fallen", 8'(a_out), 8'd0);
    hold(1'b0, 1'b0, 2);

    // 3-high burst rejected, second burst accepted
    hold(1'b1, 1'b0, 3);
    cycle(1'b0, 1'b0);
    check("a_out_burst_rejected", 8'(a_out), 8'd0);
    hold(1'b1, 1'b0, 4);
    check("a_out_second_burst", 8'(a_out), 8'd1);
    hold(1'b0, 1'b0, 6);

    // simultaneous rise, then enter sequence 10,11,01,00
    hold(1'b1, 1'b1, 4);
    check("a_rise_simul", 8'(a_rise), 8'd1);
    check("b_rise_simul", 8'(b_rise), 8'd1);
    hold(1'b0, 1'b0, 5);
    hold(1'b1, 1'b0, 5);
    hold(1'b1, 1'b1, 5);
    hold(1'b0, 1'b1, 5);
    hold(1'b0, 1'b0, 5);

    // reset mid-count, then a fresh 4-edge acceptance
    hold(1'b1, 1'b0, 2);
    pulse_reset();
    hold(1'b1, 1'b0, 3);
    check("a_out_after_reset_3", 8'(a_out), 8'd0);
    cycle(1'b1, 1'b0);
    check("a_out_after_reset_4", 8'(a_out), 8'd1);
    // reset while a pulse is visible
    pulse_reset();
    hold(1'b0, 1'b0, 2);

    // 300 single-cycle glitches on b
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
    end
`ifdef SENSOR_DEBOUNCER_GLITCH_COUNT_EN
    check("b_glitches_saturated", b_glitches, 8'd255);
`else
    check("b_glitches_disabled", b_glitches, 8'd0);
`endif
    pulse_reset();

    // random bursts of varying length on both channels, with occasional resets
    begin
      logic a, b;
      int   ra, rb;
      a = 1'b0; b = 1'b0; ra = 0; rb = 0;
      for (int i = 0; i < 3000; i++) begin
        if (ra == 0) begin a = 1'($urandom_range(0, 1)); ra = int'($urandom_range(1, 7)); end
        if (rb == 0) begin b = 1'($urandom_range(0, 1)); rb = int'($urandom_range(1, 7)); end
        ra--; rb--;
        if ($urandom_range(0, 399) == 0) pulse_reset();
        else cycle(a, b);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
